// File: rtl/ccff_loader.sv
// ccff_loader: serial loader for a configuration flip-flop chain.
// It takes host words through a valid/ready handshake and shifts them LSB first
// into the downstream chain, one bit per enabled prog_clk edge.
// Optional feature macro: CCFF_LOADER_CRC_EN enables a serial CRC-8
// (poly 0x07, init 0x00) over the shifted bits. Without it, crc is tied to 8'h00.
module ccff_loader #(
   parameter int CHAIN_LEN = 8,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              prog_rst_n,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   output logic              busy,
   output logic              done,
   output logic [7:0]        crc
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int BUF_W = $clog2(WORD_W + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [WORD_W-1:0] word_buf;
   logic [BUF_W-1:0]  buf_cnt;

   logic [31:0] rem_bits;
   logic [31:0] avail_bits;
   logic [31:0] load_bits;
   logic        shifting;
   logic        accept;
   logic        last_bit;
   logic        begin_load;

   // Handshake, bit-presentation and word-sizing decisions, all derived from registered state
   always_comb begin
      rem_bits   = 32'(CHAIN_LEN) - 32'(bit_cnt);
      avail_bits = rem_bits - 32'(buf_cnt);
      load_bits  = (avail_bits < 32'(WORD_W)) ? avail_bits : 32'(WORD_W);
      shifting   = (state == SHIFT) && (buf_cnt != '0);
      cfg_ready  = (state == SHIFT) && (buf_cnt <= BUF_W'(1)) && (rem_bits > 32'(buf_cnt));
      accept     = cfg_ready && cfg_valid;
      last_bit   = shifting && (bit_cnt == CNT_W'(CHAIN_LEN - 1));
      begin_load = ((state == IDLE) || (state == DONE)) && start;
   end

   assign ccff_shift_en = shifting;
   assign ccff_head     = shifting & word_buf[0];
   assign busy          = (state == SHIFT);
   assign done          = (state == DONE);

   // Load sequencer: state, chain bit counter and the word buffer with its fill count
   always_ff @(posedge prog_clk) begin
      if (!prog_rst_n) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         word_buf <= '0;
         buf_cnt  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state    <= SHIFT;
                  bit_cnt  <= '0;
                  word_buf <= '0;
                  buf_cnt  <= '0;
               end
            end
            SHIFT: begin
               if (shifting) begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
               if (accept) begin
                  word_buf <= cfg_data;
                  buf_cnt  <= BUF_W'(load_bits);
               end else if (shifting) begin
                  word_buf <= word_buf >> 1;
                  buf_cnt  <= buf_cnt - BUF_W'(1);
               end
               if (last_bit) begin
                  state <= DONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef CCFF_LOADER_CRC_EN
   logic crc_fb;

   assign crc_fb = crc[7] ^ ccff_head;

   // Serial CRC-8 over every bit actually pushed into the chain
   always_ff @(posedge prog_clk) begin
      if (!prog_rst_n) begin
         crc <= 8'h00;
      end else if (begin_load) begin
         crc <= 8'h00;
      end else if (shifting) begin
         crc <= {crc[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
      end
   end
`else
   assign crc = 8'h00;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: self-checking bench for ccff_loader.
// Three instances (CHAIN_LEN 8, 12, 16) are driven one load at a time. Each load's
// expected bit stream, stall count and CRC come from a transaction-level model:
// the words' bits LSB first truncated to the chain length, plus the CRC-8 of that stream.
module tb_ccff_loader;

   localparam int NDUT = 3;

   logic       prog_clk = 1'b0;
   logic       prog_rst_n;
   logic       start_s [NDUT];
   logic [7:0] data_s  [NDUT];
   logic       valid_s [NDUT];
   logic       ready_s [NDUT];
   logic       head_s  [NDUT];
   logic       sh_s    [NDUT];
   logic       busy_s  [NDUT];
   logic       done_s  [NDUT];
   logic [7:0] crc_s   [NDUT];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 prog_clk = ~prog_clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      ccff_loader #(
         .CHAIN_LEN((g == 0) ? 8 : ((g == 1) ? 12 : 16)),
         .WORD_W   (8)
      ) u_dut (
         .prog_clk     (prog_clk),
         .prog_rst_n   (prog_rst_n),
         .start        (start_s[g]),
         .cfg_data     (data_s[g]),
         .cfg_valid    (valid_s[g]),
         .cfg_ready    (ready_s[g]),
         .ccff_head    (head_s[g]),
         .ccff_shift_en(sh_s[g]),
         .busy         (busy_s[g]),
         .done         (done_s[g]),
         .crc          (crc_s[g])
      );
   end

   function automatic int len_of(input int d);
      return (d == 0) ? 8 : ((d == 1) ? 12 : 16);
   endfunction

   // Reference CRC over a bit stream; all zeros when the feature is compiled out
   function automatic logic [7:0] crc_model(input logic bits[$]);
      logic [7:0] c;
      c = 8'h00;
`ifdef CCFF_LOADER_CRC_EN
      for (int i = 0; i < bits.size(); i++) begin
         if ((c[7] ^ bits[i]) == 1'b1) c = ((c << 1) & 8'hFF) ^ 8'h07;
         else                          c = (c << 1) & 8'hFF;
      end
`endif
      return c;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkIdle(input int d, input string tag);
      checkOutput(tag, {27'd0, ready_s[d], head_s[d], sh_s[d], busy_s[d], done_s[d]}, 32'd0);
      checkOutput({tag, "_crc"}, {24'd0, crc_s[d]}, 32'd0);
   endtask

   // One load on instance d. gaps[i] = ready cycles withheld before offering word i.
   // start_pulse_cyc >= 0 pulses start mid-load; abort_after > 0 pulls reset after that many bits.
   task automatic applyStimulus(input int d, input logic [7:0] words[$], input int gaps[$],
                                input int start_pulse_cyc, input int abort_after);
      int         len;
      logic       exp_bits[$];
      logic       got[$];
      int         exp_bubbles, bubbles, wi, gap_left, cyc, last_shift_cyc;
      bit         done_seen, head_bad, ready_bad, busy_bad;
      logic [7:0] exp_crc;

      len = len_of(d);
      for (int w = 0; w < words.size(); w++)
         for (int b = 0; b < 8; b++)
            if (exp_bits.size() < len) exp_bits.push_back(words[w][b]);
      exp_bubbles = 0;
      for (int w = 1; w < gaps.size(); w++) exp_bubbles += gaps[w];
      exp_crc = crc_model(exp_bits);

      @(posedge prog_clk); #1;
      start_s[d] = 1'b1;
      valid_s[d] = 1'b0;
      @(posedge prog_clk); #1;
      start_s[d] = 1'b0;

      wi = 0; gap_left = gaps[0]; bubbles = 0; cyc = 0; last_shift_cyc = -10;
      done_seen = 0; head_bad = 0; ready_bad = 0; busy_bad = 0;
      valid_s[d] = (wi < words.size()) && (gap_left == 0);
      data_s[d]  = valid_s[d] ? words[wi] : 8'($urandom);

      while (!done_seen && cyc < 200) begin
         @(negedge prog_clk);
         cyc++;
         if (done_s[d] === 1'b1) begin
            done_seen = 1;
            checkOutput("done_latency", cyc, last_shift_cyc + 1);
            checkOutput("busy_in_done", {31'd0, busy_s[d]}, 32'd0);
         end else begin
            if (busy_s[d] !== 1'b1) busy_bad = 1;
            if (sh_s[d] === 1'b1) begin
               got.push_back(head_s[d]);
               last_shift_cyc = cyc;
            end else begin
               if (head_s[d] !== 1'b0) head_bad = 1;
               if (got.size() > 0 && got.size() < len) bubbles++;
            end
            if (ready_s[d] === 1'b1 && wi >= words.size()) ready_bad = 1;
            if (ready_s[d] === 1'b1 && valid_s[d]) begin
               wi++;
               gap_left = (wi < gaps.size()) ? gaps[wi] : 0;
            end else if (ready_s[d] === 1'b1 && gap_left > 0) begin
               gap_left--;
            end
            if (abort_after > 0 && got.size() == abort_after) begin
               prog_rst_n = 1'b0;
               valid_s[d] = 1'b0;
               @(negedge prog_clk);
               checkIdle(d, "abort_reset");
               prog_rst_n = 1'b1;
               repeat (2) @(negedge prog_clk);
               checkIdle(d, "abort_idle");
               return;
            end
            @(posedge prog_clk); #1;
            start_s[d] = (cyc == start_pulse_cyc);
            valid_s[d] = (wi < words.size()) && (gap_left == 0);
            data_s[d]  = valid_s[d] ? words[wi] : 8'($urandom);
         end
      end
      valid_s[d] = 1'b0;
      start_s[d] = 1'b0;

      checkOutput("done_seen", {31'd0, done_seen}, 32'd1);
      checkOutput("shift_count", got.size(), len);
      for (int i = 0; i < got.size() && i < len; i++)
         checkOutput($sformatf("bit%0d", i), {31'd0, got[i]}, {31'd0, exp_bits[i]});
      checkOutput("stall_cycles", bubbles, exp_bubbles);
      checkOutput("crc_done", {24'd0, crc_s[d]}, {24'd0, exp_crc});
      checkOutput("head_idle", {31'd0, head_bad}, 32'd0);
      checkOutput("ready_after_last", {31'd0, ready_bad}, 32'd0);
      checkOutput("busy_in_shift", {31'd0, busy_bad}, 32'd0);
      repeat (2) @(negedge prog_clk);
      checkOutput("done_hold", {29'd0, done_s[d], sh_s[d], ready_s[d]}, 32'd4);
      checkOutput("crc_hold", {24'd0, crc_s[d]}, {24'd0, exp_crc});
   endtask

   // Directed scenarios first, then randomized loads on random instances
   initial begin
      logic [7:0] wq[$];
      int         gq[$];
      int         d, n;

      prog_rst_n = 1'b0;
      for (int i = 0; i < NDUT; i++) begin
         start_s[i] = 1'b0;
         valid_s[i] = 1'b0;
         data_s[i]  = 8'h00;
      end
      repeat (3) @(posedge prog_clk);
      @(negedge prog_clk);
      for (int i = 0; i < NDUT; i++) checkIdle(i, $sformatf("reset_dut%0d", i));
      prog_rst_n = 1'b1;
      repeat (2) @(negedge prog_clk);
      for (int i = 0; i < NDUT; i++) checkIdle(i, $sformatf("post_reset_dut%0d", i));

      wq = {8'hA5}; gq = {0};
      applyStimulus(0, wq, gq, -1, 0);

      wq = {8'h3C, 8'hFF}; gq = {0, 0};
      applyStimulus(1, wq, gq, -1, 0);

      wq = {8'($urandom), 8'($urandom)}; gq = {0, 3};
      applyStimulus(2, wq, gq, -1, 0);

      wq = {8'h01}; gq = {0};
      applyStimulus(0, wq, gq, -1, 0);
`ifdef CCFF_LOADER_CRC_EN
      checkOutput("crc_word01", {24'd0, crc_s[0]}, 32'h89);
`else
      checkOutput("crc_word01", {24'd0, crc_s[0]}, 32'h00);
`endif

      wq = {8'($urandom), 8'($urandom)}; gq = {1, 0};
      applyStimulus(1, wq, gq, 3, 0);

      wq = {8'($urandom)}; gq = {0};
      applyStimulus(0, wq, gq, -1, 5);
      wq = {8'($urandom)}; gq = {0};
      applyStimulus(0, wq, gq, -1, 0);

      repeat (6) begin
         d = int'($urandom_range(0, 2));
         n = (len_of(d) + 7) / 8;
         wq = {}; gq = {};
         for (int i = 0; i < n; i++) begin
            wq.push_back(8'($urandom));
            gq.push_back(int'($urandom_range(0, 3)));
         end
         applyStimulus(d, wq, gq, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 5)) : -1, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Safety net so the run always ends
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameter: CHAIN_LEN, default 8; total configuration-chain bits downstream (sum of all mux mem bits on the chain).
REQ-002 Parameter: WORD_W, default 8; width of the host configuration word.
REQ-003 Port: prog_clk, input, 1; the single clock; all state updates on its rising edge.
REQ-004 Port: prog_rst_n, input, 1; reset, synchronous and active-low.
REQ-005 Port: start, input, 1; begins a load when sampled high in IDLE or DONE.
REQ-006 Port: cfg_data, input, WORD_W; configuration word, shifted LSB first.
REQ-007 Port: cfg_valid, input, 1; cfg_data is valid.
REQ-008 Port: cfg_ready, output, 1; loader accepts cfg_data this cycle.
REQ-009 Port: ccff_head, output, 1; serial bit into the downstream chain head.
REQ-010 Port: ccff_shift_en, output, 1; chain clock-enable; the chain advances one bit on each edge where this is high.
REQ-011 Port: busy, output, 1; high in state SHIFT.
REQ-012 Port: done, output, 1; high in state DONE.
REQ-013 Port: crc, output, 8; CRC-8 of the bits shifted (see Configuration).

Function
REQ-014 The block SHALL implement states IDLE, SHIFT and DONE.
REQ-015 Transitions: IDLE/DONE->SHIFT on start; SHIFT->DONE on the cycle the CHAIN_LEN-th bit is shifted; start in SHIFT is ignored.
REQ-016 Entering SHIFT SHALL clear the bit counter (width clog2(CHAIN_LEN+1)), empty the word buffer and reset crc to 8'h00.
REQ-017 A word transfers only when cfg_valid and cfg_ready are both high.
REQ-018 cfg_ready is high only in SHIFT, when the word buffer is empty or holds its last unshifted bit, and remaining bits exceed the bits already buffered.
REQ-019 An accepted word drives its bit 0 on ccff_head in the following cycle; a word accepted while the buffer's last bit shifts follows it with no bubble.
REQ-020 ccff_shift_en is high exactly in the cycles a valid buffered bit is presented on ccff_head; the counter increments by 1 in each such cycle.
REQ-021 If the buffer is empty in SHIFT (underrun), ccff_shift_en is 0, ccff_head is 0, and the counter and crc hold; no error is flagged.
REQ-022 When CHAIN_LEN is not a multiple of WORD_W, the unused upper bits of the final word are discarded without being shifted.
REQ-023 Outside shifting cycles, ccff_head is 0 and ccff_shift_en is 0.
REQ-024 done holds high until the next start; crc holds its final value in DONE.

Reset
REQ-025 When prog_rst_n is low at a prog_clk edge: the state goes to IDLE, and the counter, buffer and crc clear.
REQ-026 During and after reset, until start: cfg_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, crc=8'h00.
REQ-027 Reset asserted mid-load aborts the load immediately; partial chain contents are not restored.

Configuration
REQ-028 Macro CCFF_LOADER_CRC_EN: when defined, crc is updated on each shift-enabled cycle with a serial CRC-8 using polynomial 0x07 and init 0x00: fb = crc[7]^ccff_head; crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00).
REQ-029 Without CCFF_LOADER_CRC_EN: the crc port still exists, is constantly 8'h00, and no CRC logic is synthesized.

Verification
REQ-030 CHAIN_LEN=8, start, then 0xA5 accepted -> ccff_head = 1,0,1,0,0,1,0,1 on 8 consecutive shift_en cycles; done=1 the next cycle; cfg_ready=0 after the word.
REQ-031 CHAIN_LEN=12, words 0x3C then 0xFF back-to-back -> 12 contiguous shift_en cycles, bits 0,0,1,1,1,1,0,0,1,1,1,1; cfg_ready drops after the second word.
REQ-032 CHAIN_LEN=16, cfg_valid deasserted 3 cycles between words -> ccff_shift_en=0 for exactly 3 cycles, counter frozen, 16 bits total, then done.
REQ-033 Reset pulled low after 5 shifted bits -> next cycle: IDLE, all outputs 0; a fresh start reloads correctly.
REQ-034 CCFF_LOADER_CRC_EN defined, CHAIN_LEN=8, word 0x01 -> crc=8'h89 in DONE; same test without the macro -> crc=8'h00.
REQ-035 start pulsed during SHIFT -> no effect on the counter, bits or crc.
